// File: rtl/wb_scheduler.sv
// Write-back port scheduler: ALU results win the single regfile write port, multiply results
// are parked in a small ordered buffer and drained on idle slots. Optional stats: WB_SCHED_STATS_EN.
module wb_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int REG_ADDR   = 5,
    parameter int REG_SIZE   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_regwrite,
    input  logic [REG_ADDR-1:0] alu_wreg,
    input  logic [REG_SIZE-1:0] alu_wdata,
    input  logic                mul_issue,
    input  logic                mul_regwrite,
    input  logic [REG_ADDR-1:0] mul_wreg,
    input  logic [REG_SIZE-1:0] mul_wdata,
    input  logic [REG_ADDR-1:0] query_reg,
    output logic                query_hit,
    output logic                mul_stall,
    output logic                wb_regwrite,
    output logic [REG_ADDR-1:0] wb_wreg,
    output logic [REG_SIZE-1:0] wb_wdata,
    output logic                proto_err,
    output logic [15:0]         defer_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Buffer is kept compacted with the oldest entry in slot 0: squashed entries are removed
    // the cycle they die, so a dead entry never holds a slot a live multiply might need.
    logic [REG_ADDR-1:0] buf_reg  [FIFO_DEPTH];
    logic [REG_SIZE-1:0] buf_data [FIFO_DEPTH];
    logic [CW-1:0]       buf_cnt;
    logic [CW-1:0]       out_cnt;

    logic [REG_ADDR-1:0] reg_nxt  [FIFO_DEPTH];
    logic [REG_SIZE-1:0] data_nxt [FIFO_DEPTH];
    logic [CW-1:0]       cnt_nxt;
    logic [CW-1:0]       out_nxt;
    logic                stall_nxt;

    logic                vld_p0;
    logic [REG_ADDR-1:0] reg_p0;
    logic [REG_SIZE-1:0] data_p0;

    logic                pop_head;
    logic                mul_direct;
    logic                mul_drop;
    logic                push_req;
    logic                push_ok;
    logic                overflow;
    int                  keep_n;
    int                  squash_n;
    int                  retire_n;
    int                  out_sum;

    // p0: source selection, squash, buffer update and credit accounting
    always_comb begin
        reg_nxt    = buf_reg;
        data_nxt   = buf_data;
        pop_head   = !alu_regwrite && (buf_cnt != '0);
        mul_direct = !alu_regwrite && (buf_cnt == '0) && mul_regwrite;
        mul_drop   = alu_regwrite && mul_regwrite && (mul_wreg == alu_wreg);
        push_req   = mul_regwrite && !mul_direct && !mul_drop;
        keep_n     = 0;
        squash_n   = 0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (k < int'(buf_cnt)) begin
                if (alu_regwrite && (buf_reg[k] == alu_wreg)) begin
                    squash_n = squash_n + 1;
                end else if (!(pop_head && (k == 0))) begin
                    reg_nxt[IW'(keep_n)]  = buf_reg[k];
                    data_nxt[IW'(keep_n)] = buf_data[k];
                    keep_n = keep_n + 1;
                end
            end
        end
        push_ok  = push_req && (keep_n < FIFO_DEPTH);
        overflow = push_req && !push_ok;
        if (push_ok) begin
            reg_nxt[IW'(keep_n)]  = mul_wreg;
            data_nxt[IW'(keep_n)] = mul_wdata;
        end
        cnt_nxt = CW'(keep_n + int'(push_ok));

        // A dropped overflow push is gone for good, so it also returns its credit.
        retire_n = squash_n + int'(mul_drop) + int'(mul_direct) + int'(pop_head) + int'(overflow);
        out_sum  = int'(out_cnt) + int'(mul_issue) - retire_n;
        if (out_sum < 0) begin
            out_sum = 0;
        end else if (out_sum > FIFO_DEPTH) begin
            out_sum = FIFO_DEPTH;
        end
        out_nxt   = CW'(out_sum);
        stall_nxt = (out_sum >= FIFO_DEPTH);
    end

    always_comb begin
        vld_p0  = 1'b0;
        reg_p0  = '0;
        data_p0 = '0;
        if (alu_regwrite) begin
            vld_p0  = 1'b1;
            reg_p0  = alu_wreg;
            data_p0 = alu_wdata;
        end else if (pop_head) begin
            vld_p0  = 1'b1;
            reg_p0  = buf_reg[0];
            data_p0 = buf_data[0];
        end else if (mul_direct) begin
            vld_p0  = 1'b1;
            reg_p0  = mul_wreg;
            data_p0 = mul_wdata;
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if ((k < int'(buf_cnt)) && (buf_reg[k] == query_reg)) begin
                query_hit = 1'b1;
            end
        end
    end

    // p1: registered write port and control state
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cnt     <= '0;
            out_cnt     <= '0;
            mul_stall   <= 1'b0;
            proto_err   <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_wreg     <= '0;
            wb_wdata    <= '0;
        end else begin
            buf_cnt     <= cnt_nxt;
            out_cnt     <= out_nxt;
            mul_stall   <= stall_nxt;
            wb_regwrite <= vld_p0;
            wb_wreg     <= reg_p0;
            wb_wdata    <= data_p0;
            if (overflow || (mul_issue && mul_stall)) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        buf_reg  <= reg_nxt;
        buf_data <= data_nxt;
    end

`ifdef WB_SCHED_STATS_EN
    logic [15:0] defer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            defer_q <= '0;
        end else if (push_ok && (defer_q != 16'hFFFF)) begin
            defer_q <= defer_q + 16'd1;
        end
    end

    assign defer_cnt = defer_q;
`else
    assign defer_cnt = '0;
`endif

endmodule
